// File: rtl/spi_ram_bridge.sv
// spi_ram_bridge: SPI slave decoding 2-bit command frames into pointer updates and single-port RAM reads/writes
module spi_ram_bridge #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter bit AUTO_INC   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic frame_abort
);
  localparam int MW = ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW = $clog2(MW + 1);
  localparam int IW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] TOP = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [CW-1:0] DLEN = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] DLAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] ALAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [2:0] {IDLE, CMD, RX_PAYLOAD, RD_FETCH, TX, DONE} state_t;

  state_t state, state_n;
  logic [1:0] cmd, cmd_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [MW-2:0] rx, rx_n;
  logic [MW-1:0] shift;
  logic [DATA_WIDTH-1:0] sh, sh_n, fetch;
  logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic miso_n, abort_n, we, re, wr_ok, rd_ok, last;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic [ADDR_WIDTH-1:0] bump(input logic [ADDR_WIDTH-1:0] p);
    return (p >= TOP) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  assign wr_ok = {1'b0, wr_ptr} < DEPTH;
  assign rd_ok = {1'b0, rd_ptr} < DEPTH;
  assign shift = {rx, MOSI};
  assign last  = cnt == (cmd == 2'b01 ? DLAST : ALAST);

  always_comb begin
    state_n  = state;
    cmd_n    = cmd;
    cnt_n    = cnt;
    rx_n     = rx;
    sh_n     = sh;
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    miso_n   = 1'b0;
    abort_n  = 1'b0;
    we       = 1'b0;
    re       = 1'b0;
    if (SS_n) begin
      state_n = IDLE;
      abort_n = state != IDLE && state != DONE;
    end else begin
      case (state)
        IDLE: begin
          state_n = CMD;
          cmd_n   = {MOSI, 1'b0};
        end
        CMD: begin
          cmd_n   = {cmd[1], MOSI};
          cnt_n   = '0;
          re      = cmd[1] & MOSI;
          state_n = re ? RD_FETCH : RX_PAYLOAD;
        end
        RX_PAYLOAD: begin
          rx_n  = shift[MW-2:0];
          cnt_n = cnt + ONE;
          if (last) begin
            state_n = DONE;
            we      = cmd[0] & wr_ok;
            if (cmd[1])
              rd_ptr_n = shift[ADDR_WIDTH-1:0];
            else if (!cmd[0])
              wr_ptr_n = shift[ADDR_WIDTH-1:0];
            else if (AUTO_INC)
              wr_ptr_n = bump(wr_ptr);
          end
        end
        RD_FETCH: begin
          state_n = TX;
          miso_n  = fetch[DATA_WIDTH-1];
          sh_n    = {fetch[DATA_WIDTH-2:0], 1'b0};
          cnt_n   = ONE;
        end
        TX: begin
          // cnt counts bits already driven; one idle edge after the LSB closes the frame
          if (cnt == DLEN) begin
            state_n = DONE;
          end else begin
            miso_n = sh[DATA_WIDTH-1];
            sh_n   = {sh[DATA_WIDTH-2:0], 1'b0};
            cnt_n  = cnt + ONE;
            if (AUTO_INC && cnt == DLAST) rd_ptr_n = bump(rd_ptr);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd         <= '0;
      cnt         <= '0;
      rx          <= '0;
      sh          <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      MISO        <= 1'b0;
      busy        <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_n;
      cmd         <= cmd_n;
      cnt         <= cnt_n;
      rx          <= rx_n;
      sh          <= sh_n;
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      MISO        <= miso_n;
      busy        <= state_n != IDLE;
      frame_abort <= abort_n;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr[IW-1:0]] <= shift[DATA_WIDTH-1:0];
    if (re) fetch <= rd_ok ? mem[rd_ptr[IW-1:0]] : '0;
  end
endmodule

// File: tb/tb_spi_ram_bridge.sv
// tb_spi_ram_bridge: three bridge configurations driven by directed and random frames against a word-level model
module tb_spi_ram_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mosi = 1'b0;
  logic [2:0] ss = '1;
  logic [2:0] miso, busy, fa;
  int errs = 0;
  int checks = 0;
  int dw[3] = '{8, 8, 16};
  int aw[3] = '{8, 8, 4};
  int dep[3] = '{256, 200, 16};
  bit inc[3] = '{1'b1, 1'b1, 1'b0};
  logic [15:0] mm[3][256];
  bit vd[3][256];
  int wp[3];
  int rp[3];

  typedef struct packed {
    logic [15:0] rd;
    logic [15:0] ev;
    logic kn;
    logic f1;
    logic f2;
    logic bz;
    logic idle;
    logic mt;
  } res_t;

  always #5 clk = ~clk;

  spi_ram_bridge u0 (.clk(clk), .rst_n(rst_n), .SS_n(ss[0]), .MOSI(mosi), .MISO(miso[0]), .busy(busy[0]), .frame_abort(fa[0]));
  spi_ram_bridge #(.MEM_DEPTH(200)) u1 (.clk(clk), .rst_n(rst_n), .SS_n(ss[1]), .MOSI(mosi), .MISO(miso[1]), .busy(busy[1]), .frame_abort(fa[1]));
  spi_ram_bridge #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .MEM_DEPTH(16), .AUTO_INC(1'b0)) u2 (.clk(clk), .rst_n(rst_n), .SS_n(ss[2]), .MOSI(mosi), .MISO(miso[2]), .busy(busy[2]), .frame_abort(fa[2]));

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ab<0: complete frame; ab=0: SS_n rises after the first command bit; ab>0: after edge 2 plus ab-1 more edges
  task automatic frame(input int u, input logic [1:0] c, input logic [15:0] pl, input int ab, output res_t r);
    int len;
    int n;
    r = '0;
    len = c == 2'b01 ? dw[u] : aw[u];
    ss[u] = 1'b0;
    mosi = c[1];
    tick();
    r.bz = busy[u];
    if (ab != 0) begin
      mosi = c[0];
      tick();
      n = ab > 0 ? ab - 1 : (c == 2'b11 ? dw[u] + 3 : len + 2);
      for (int j = 0; j < n; j++) begin
        mosi = (c != 2'b11 && j < len) ? pl[len-1-j] : 1'($urandom);
        tick();
        if (c == 2'b11 && j < dw[u]) r.rd[dw[u]-1-j] = miso[u];
      end
      r.mt = miso[u];
    end
    ss[u] = 1'b1;
    tick();
    r.f1 = fa[u];
    r.idle = !busy[u] && !miso[u];
    tick();
    r.f2 = fa[u];
  endtask

  task automatic model(input int u, input logic [1:0] c, input logic [15:0] pl, input int ab, output logic [15:0] ev, output logic kn);
    ev = '0;
    kn = 1'b1;
    if (ab < 0) begin
      if (c == 2'b00) begin
        wp[u] = int'(pl) % (1 << aw[u]);
      end else if (c == 2'b10) begin
        rp[u] = int'(pl) % (1 << aw[u]);
      end else if (c == 2'b01) begin
        if (wp[u] < dep[u]) begin
          mm[u][wp[u]] = 16'(int'(pl) % (1 << dw[u]));
          vd[u][wp[u]] = 1'b1;
        end
        if (inc[u]) wp[u] = (wp[u] >= dep[u] - 1) ? 0 : wp[u] + 1;
      end else begin
        if (rp[u] < dep[u]) begin
          ev = mm[u][rp[u]];
          kn = vd[u][rp[u]];
        end
        if (inc[u]) rp[u] = (rp[u] >= dep[u] - 1) ? 0 : rp[u] + 1;
      end
    end
  endtask

  task automatic xfer(input int u, input logic [1:0] c, input logic [15:0] pl, input int ab, output res_t r);
    frame(u, c, pl, ab, r);
    model(u, c, pl, ab, r.ev, r.kn);
  endtask

  task automatic test_reset;
    res_t r;
    repeat (3) tick();
    checks++;
    if ({miso, busy, fa} !== 9'b0) begin
      errs++;
      $display("FAIL reset_outputs got=%b want=%b", {miso, busy, fa}, 9'b0);
    end
    rst_n = 1'b1;
    tick();
    xfer(0, 2'b00, 16'h00, -1, r);
    xfer(0, 2'b01, 16'hC3, -1, r);
    xfer(0, 2'b00, 16'h21, -1, r);
    xfer(0, 2'b01, 16'hA5, -1, r);
    xfer(0, 2'b10, 16'h21, -1, r);
    ss[0] = 1'b0;
    mosi = 1'b1;
    repeat (3) tick();
    checks++;
    if (miso[0] !== 1'b1 || busy[0] !== 1'b1) begin
      errs++;
      $display("FAIL reset_pre_tx got miso=%b busy=%b want 1 1", miso[0], busy[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({miso, busy, fa} !== 9'b0) begin
      errs++;
      $display("FAIL reset_midframe got=%b want=%b", {miso, busy, fa}, 9'b0);
    end
    ss = '1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wp[i] = 0;
      rp[i] = 0;
    end
    tick();
    xfer(0, 2'b11, 16'h0, -1, r);
    checks++;
    if (r.rd !== 16'hC3) begin
      errs++;
      $display("FAIL reset_rd_ptr got=%h want=%h", r.rd, 16'hC3);
    end
  endtask

  task automatic test_basic;
    res_t r;
    xfer(0, 2'b00, 16'h10, -1, r);
    xfer(0, 2'b01, 16'hA5, -1, r);
    xfer(0, 2'b10, 16'h10, -1, r);
    xfer(0, 2'b11, 16'h0, -1, r);
    checks++;
    if (r.rd !== 16'hA5) begin
      errs++;
      $display("FAIL basic_rd got=%h want=%h", r.rd, 16'hA5);
    end
    checks++;
    if (r.mt !== 1'b0 || r.bz !== 1'b1) begin
      errs++;
      $display("FAIL basic_done got miso=%b busy=%b want 0 1", r.mt, r.bz);
    end
    checks++;
    if (r.idle !== 1'b1 || r.f1 !== 1'b0 || r.f2 !== 1'b0) begin
      errs++;
      $display("FAIL basic_end got idle=%b abort=%b%b want 1 00", r.idle, r.f1, r.f2);
    end
  endtask

  task automatic test_wrap;
    res_t r;
    xfer(0, 2'b00, 16'hFF, -1, r);
    xfer(0, 2'b01, 16'h11, -1, r);
    xfer(0, 2'b01, 16'h22, -1, r);
    xfer(0, 2'b10, 16'hFF, -1, r);
    xfer(0, 2'b11, 16'h0, -1, r);
    checks++;
    if (r.rd !== 16'h11) begin
      errs++;
      $display("FAIL wrap_rd0 got=%h want=%h", r.rd, 16'h11);
    end
    xfer(0, 2'b11, 16'h0, -1, r);
    checks++;
    if (r.rd !== 16'h22) begin
      errs++;
      $display("FAIL wrap_rd1 got=%h want=%h", r.rd, 16'h22);
    end
  endtask

  task automatic test_range;
    res_t r;
    xfer(1, 2'b00, 16'hC8, -1, r);
    xfer(1, 2'b01, 16'h5A, -1, r);
    xfer(1, 2'b01, 16'h66, -1, r);
    xfer(1, 2'b10, 16'hC8, -1, r);
    xfer(1, 2'b11, 16'h0, -1, r);
    checks++;
    if (r.rd !== 16'h00) begin
      errs++;
      $display("FAIL range_rd got=%h want=%h", r.rd, 16'h00);
    end
    xfer(1, 2'b11, 16'h0, -1, r);
    checks++;
    if (r.rd !== 16'h66) begin
      errs++;
      $display("FAIL range_wrap got=%h want=%h", r.rd, 16'h66);
    end
  endtask

  task automatic test_abort;
    res_t r;
    xfer(0, 2'b00, 16'h40, -1, r);
    xfer(0, 2'b01, 16'h99, -1, r);
    xfer(0, 2'b00, 16'h40, -1, r);
    xfer(0, 2'b01, 16'h3C, 6, r);
    checks++;
    if (r.f1 !== 1'b1 || r.f2 !== 1'b0 || r.idle !== 1'b1) begin
      errs++;
      $display("FAIL abort_wr got pulse=%b%b idle=%b want 10 1", r.f1, r.f2, r.idle);
    end
    xfer(0, 2'b01, 16'h77, 0, r);
    checks++;
    if (r.f1 !== 1'b1 || r.f2 !== 1'b0) begin
      errs++;
      $display("FAIL abort_cmd got pulse=%b%b want 10", r.f1, r.f2);
    end
    xfer(0, 2'b10, 16'h40, -1, r);
    xfer(0, 2'b11, 16'h0, -1, r);
    checks++;
    if (r.rd !== 16'h99) begin
      errs++;
      $display("FAIL abort_mem got=%h want=%h", r.rd, 16'h99);
    end
    xfer(0, 2'b01, 16'h5E, -1, r);
    xfer(0, 2'b10, 16'h40, -1, r);
    xfer(0, 2'b11, 16'h0, 4, r);
    checks++;
    if (r.f1 !== 1'b1 || r.idle !== 1'b1) begin
      errs++;
      $display("FAIL abort_rd got pulse=%b idle=%b want 1 1", r.f1, r.idle);
    end
    xfer(0, 2'b11, 16'h0, -1, r);
    checks++;
    if (r.rd !== 16'h5E) begin
      errs++;
      $display("FAIL abort_ptrs got=%h want=%h", r.rd, 16'h5E);
    end
  endtask

  task automatic test_noinc;
    res_t r;
    xfer(2, 2'b00, 16'h3, -1, r);
    xfer(2, 2'b01, 16'hBEEF, -1, r);
    xfer(2, 2'b10, 16'h3, -1, r);
    for (int i = 0; i < 2; i++) begin
      xfer(2, 2'b11, 16'h0, -1, r);
      checks++;
      if (r.rd !== 16'hBEEF || r.mt !== 1'b0) begin
        errs++;
        $display("FAIL noinc_rd%0d got=%h miso=%b want=%h 0", i, r.rd, r.mt, 16'hBEEF);
      end
    end
  endtask

  task automatic test_random;
    res_t r;
    int u;
    int len;
    int ab;
    logic [1:0] c;
    logic [15:0] pl;
    for (int i = 0; i < 150; i++) begin
      u = $urandom_range(0, 2);
      c = 2'($urandom);
      len = c == 2'b10 || c == 2'b00 ? aw[u] : dw[u];
      if (c[0])
        pl = 16'($urandom);
      else if (u == 2)
        pl = 16'($urandom_range(0, 15));
      else if ($urandom_range(0, 1) == 0)
        pl = 16'($urandom_range(0, 5));
      else
        pl = 16'(u == 0 ? $urandom_range(250, 255) : $urandom_range(196, 203));
      ab = $urandom_range(0, 4) == 0 ? int'($urandom_range(0, len)) : -1;
      xfer(u, c, pl, ab, r);
      checks++;
      if (r.f1 !== 1'(ab >= 0) || r.f2 !== 1'b0 || r.idle !== 1'b1) begin
        errs++;
        $display("FAIL rand_end #%0d u%0d cmd=%b got pulse=%b%b idle=%b want %b0 1", i, u, c, r.f1, r.f2, r.idle, ab >= 0);
      end
      if (c == 2'b11 && ab < 0 && r.kn) begin
        checks++;
        if (r.rd !== r.ev) begin
          errs++;
          $display("FAIL rand_rd #%0d u%0d got=%h want=%h", i, u, r.rd, r.ev);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_range();
    test_abort();
    test_noinc();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
